replacer_extend_multi: RTL

- Parametrised successor of the single-bit replacer.
- Consumes a video word FIFO and a count-token FIFO. Each token walks a bit cursor (MSB-first) across the video stream and optionally replaces the bit it lands on.
- Unlike the previous generation, any number of replacements per word are accumulated in a mask. Word width, token width and replacement mode are generic.
- Sits between the entropy/sign stage FIFOs and the packer output FIFO.

---
 rtl/replacer_extend_multi.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/replacer_extend_multi.sv
// ---------------------------------------------------------------------------
// replacer_extend_multi
//
// Purpose:
//   Walks a bit cursor (MSB-first) across a stream of video words read from a
//   video FIFO. Each count token read from a token FIFO advances the cursor by
//   its skip distance and, when its replace flag is set, marks the bit it lands
//   on in a per-word replacement mask. When a token's skip runs past bit 0 the
//   current word is emitted with every marked bit replaced, and the remaining
//   skip is carried into the next word. Any number of replacements per word are
//   accumulated before the word is emitted.
//
// Parameters:
//   DATA_W  video word width (power of two, 8..64)
//   CNT_W   token width: bit CNT_W-1 = replace flag, bits CNT_W-2:0 = skip
//   MODE    0: marked bits take ~last_sign_in
//           1: marked bits take  last_sign_in
//           2: marked bits are inverted
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   clk_en         global enable; low freezes all state
//   vid_in         video FIFO read data (valid the cycle after vid_rd)
//   vid_empty      video FIFO empty
//   cnt_in         token FIFO read data (valid the cycle after cnt_rd)
//   cnt_empty      token FIFO empty
//   last_sign_in   replacement source for MODE 0/1, sampled on the emit cycle
//   flush          pulse: emit the current word now, cursor/mask restart
//   out_afull      output FIFO almost full; stalls the block like clk_en=0
//   vid_rd         video FIFO read strobe (combinational)
//   cnt_rd         token FIFO read strobe (combinational)
//   data_out       emitted word (registered)
//   data_wr        output FIFO write strobe (registered, one cycle per word)
//
// Optional feature (macro REPLACER_STATS_EN):
//   stat_words     number of emitted words (wraps modulo 2^32)
//   stat_repl      number of mask bits carried by emitted words (wraps)
//   Both clear on rst and hold while the block is stalled.
// ---------------------------------------------------------------------------
module replacer_extend_multi #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] vid_in,
    input  logic              vid_empty,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              cnt_empty,
    input  logic              last_sign_in,
    input  logic              flush,
    input  logic              out_afull,
    output logic              vid_rd,
    output logic              cnt_rd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_wr
`ifdef REPLACER_STATS_EN
    ,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_repl
`endif
);

    localparam int CUR_W  = $clog2(DATA_W);
    localparam int SKIP_W = CNT_W - 1;
    // Wide enough for both the skip field and cursor+1 (which reaches DATA_W),
    // so the comparison and subtraction never wrap.
    localparam int CMP_W  = (SKIP_W > CUR_W + 1) ? SKIP_W : CUR_W + 1;
    localparam logic [CUR_W-1:0] CUR_TOP = CUR_W'(DATA_W - 1);

    // What the block does with the current word this cycle.
    typedef enum logic [1:0] {
        ACT_IDLE,     // nothing to do, or stalled
        ACT_CONSUME,  // token lands inside the word: move cursor, maybe mark
        ACT_SPAN,     // token runs past bit 0: emit word, carry the remainder
        ACT_FLUSH     // forced emit, token untouched
    } action_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] word_q,     word_d;
    logic              word_vld_q, word_vld_d;
    logic              vid_land_q, vid_land_d;   // video read returns this cycle
    logic [SKIP_W-1:0] tok_skip_q, tok_skip_d;
    logic              tok_flag_q, tok_flag_d;
    logic              tok_vld_q,  tok_vld_d;
    logic              cnt_land_q, cnt_land_d;   // token read returns this cycle
    logic [CUR_W-1:0]  cursor_q,   cursor_d;
    logic [DATA_W-1:0] mask_q,     mask_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_wr_q,  data_wr_d;

    // -----------------------------------------------------------------------
    // Effective operands
    // A FIFO read that returns this cycle is used directly from the FIFO data
    // bus, so a freshly read word or token can be acted on in its return cycle.
    // That is what sustains one emitted word / one consumed token per cycle.
    // A read is only ever issued into an empty (or emptying) holding register,
    // so the bypass and the register contents are never both live.
    // -----------------------------------------------------------------------
    logic              en;
    logic              w_vld;
    logic [DATA_W-1:0] w_data;
    logic              t_vld;
    logic [SKIP_W-1:0] t_skip;
    logic              t_flag;

    assign en     = clk_en && !out_afull;
    assign w_vld  = word_vld_q || vid_land_q;
    assign w_data = vid_land_q ? vid_in : word_q;
    assign t_vld  = tok_vld_q || cnt_land_q;
    assign t_skip = cnt_land_q ? cnt_in[SKIP_W-1:0] : tok_skip_q;
    assign t_flag = cnt_land_q ? cnt_in[CNT_W-1]    : tok_flag_q;

    // -----------------------------------------------------------------------
    // Cursor arithmetic
    // r = bits still ahead of (and including) the cursor in this word.
    // -----------------------------------------------------------------------
    logic [CMP_W-1:0] s_ext;
    logic [CMP_W-1:0] r_ext;
    logic [CMP_W-1:0] rem_ext;
    logic [CUR_W-1:0] target;
    logic             lands_in_word;

    assign s_ext         = CMP_W'(t_skip);
    assign r_ext         = CMP_W'(cursor_q) + CMP_W'(1);
    assign lands_in_word = s_ext < r_ext;
    // Only meaningful when the token spans the word (s >= r), so no wrap.
    assign rem_ext       = s_ext - r_ext;
    // Only meaningful when the token lands in the word (s <= cursor).
    assign target        = cursor_q - s_ext[CUR_W-1:0];

    // -----------------------------------------------------------------------
    // Action decode. Flush has priority over token processing; both need a
    // word to act on, and nothing happens while stalled.
    // -----------------------------------------------------------------------
    action_e action;
    logic    emit;

    always_comb begin
        action = ACT_IDLE;
        if (en && w_vld) begin
            if (flush) begin
                action = ACT_FLUSH;
            end else if (t_vld) begin
                action = lands_in_word ? ACT_CONSUME : ACT_SPAN;
            end
        end
    end

    assign emit = (action == ACT_SPAN) || (action == ACT_FLUSH);

    // -----------------------------------------------------------------------
    // FIFO read strobes: refill a holding register when it is empty or is
    // being released this cycle. An in-flight read shows up as w_vld/t_vld
    // through the landing flag, which blocks a second read. Reads are held
    // off during reset so FIFO contents are never lost to a cleared register.
    // -----------------------------------------------------------------------
    assign vid_rd = rst && en && !vid_empty && (!w_vld || emit);
    assign cnt_rd = rst && en && !cnt_empty && (!t_vld || (action == ACT_CONSUME));

    // -----------------------------------------------------------------------
    // Emitted word: every marked bit is replaced according to MODE.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] emit_word;

    always_comb begin
        emit_word = w_data;
        for (int i = 0; i < DATA_W; i++) begin
            if (MODE == 2) begin
                emit_word[i] = w_data[i] ^ mask_q[i];
            end else if (mask_q[i]) begin
                emit_word[i] = (MODE == 1) ? last_sign_in : ~last_sign_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets its hold value first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        word_d     = word_q;
        word_vld_d = word_vld_q;
        tok_skip_d = tok_skip_q;
        tok_flag_d = tok_flag_q;
        tok_vld_d  = tok_vld_q;
        cursor_d   = cursor_q;
        mask_d     = mask_q;
        data_out_d = data_out_q;
        data_wr_d  = emit;
        vid_land_d = vid_rd;
        cnt_land_d = cnt_rd;

        // A returning read is always captured, even while stalled; the FIFO
        // has already advanced and the data would otherwise be lost.
        if (vid_land_q) begin
            word_d     = vid_in;
            word_vld_d = 1'b1;
        end
        if (cnt_land_q) begin
            tok_skip_d = cnt_in[SKIP_W-1:0];
            tok_flag_d = cnt_in[CNT_W-1];
            tok_vld_d  = 1'b1;
        end

        unique case (action)
            ACT_CONSUME: begin
                cursor_d  = target;
                tok_vld_d = 1'b0;
                if (t_flag) begin
                    mask_d[target] = 1'b1;
                end
            end
            ACT_SPAN: begin
                // Token stays; its remaining distance is measured from bit
                // DATA_W-1 of the next word.
                tok_skip_d = rem_ext[SKIP_W-1:0];
                tok_flag_d = t_flag;
                cursor_d   = CUR_TOP;
                mask_d     = '0;
                word_vld_d = 1'b0;
                data_out_d = emit_word;
            end
            ACT_FLUSH: begin
                cursor_d   = CUR_TOP;
                mask_d     = '0;
                word_vld_d = 1'b0;
                data_out_d = emit_word;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_vld_q <= 1'b0;
            vid_land_q <= 1'b0;
            tok_vld_q  <= 1'b0;
            cnt_land_q <= 1'b0;
            cursor_q   <= CUR_TOP;
            mask_q     <= '0;
            data_out_q <= '0;
            data_wr_q  <= 1'b0;
        end else begin
            word_vld_q <= word_vld_d;
            vid_land_q <= vid_land_d;
            tok_vld_q  <= tok_vld_d;
            cnt_land_q <= cnt_land_d;
            cursor_q   <= cursor_d;
            mask_q     <= mask_d;
            data_out_q <= data_out_d;
            data_wr_q  <= data_wr_d;
        end
    end

    // NOTE: payload registers are qualified by their valid flags, so they are
    // deliberately left out of reset; this keeps rst off their enable path.
    always_ff @(posedge clk) begin
        word_q     <= word_d;
        tok_skip_q <= tok_skip_d;
        tok_flag_q <= tok_flag_d;
    end

    assign data_out = data_out_q;
    assign data_wr  = data_wr_q;

`ifdef REPLACER_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics: words emitted and replacement bits carried by them.
    // -----------------------------------------------------------------------
    function automatic logic [31:0] popcount(input logic [DATA_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    logic [31:0] stat_words_q;
    logic [31:0] stat_repl_q;

    // emit already implies en, so the counters hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_words_q <= '0;
            stat_repl_q  <= '0;
        end else if (emit) begin
            stat_words_q <= stat_words_q + 32'd1;
            stat_repl_q  <= stat_repl_q + popcount(mask_q);
        end
    end

    assign stat_words = stat_words_q;
    assign stat_repl  = stat_repl_q;
`endif

endmodule
